// File: rtl/pad_ctrl_seq_if.sv
// Config port of the pad controller: held request with index/data, grant,
// read-back of the currently driven config and the turnaround busy flag.
interface pad_ctrl_seq_if #(
    parameter int NumPads = 8
);
    localparam int IdxW = (NumPads > 1) ? $clog2(NumPads) : 1;

    logic            cfg_req_i;
    logic            cfg_gnt_o;
    logic [IdxW-1:0] cfg_idx_i;
    logic [7:0]      cfg_data_i;
    logic [7:0]      cfg_rdata_o;
    logic            busy_o;

    modport master (
        output cfg_req_i, cfg_idx_i, cfg_data_i,
        input  cfg_gnt_o, cfg_rdata_o, busy_o
    );

    modport slave (
        input  cfg_req_i, cfg_idx_i, cfg_data_i,
        output cfg_gnt_o, cfg_rdata_o, busy_o
    );
endinterface

// File: rtl/pad_ctrl_seq.sv
// Core-side padframe controller: per-pad config registers, break-before-make
// direction turnaround and a pad-input synchroniser.
module pad_ctrl_seq #(
    parameter int NumPads    = 8,
    parameter int TurnCycles = 2,
    parameter int SyncStages = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    pad_ctrl_seq_if.slave      cfg,
    input  logic [NumPads-1:0] gpio_out_i,
    output logic [NumPads-1:0] gpio_in_o,
    output logic [NumPads-1:0] pad_a_o,
    output logic [NumPads-1:0] pad_oe_o,
    output logic [NumPads-1:0] pad_ie_o,
    output logic [NumPads-1:0] pad_ds0_o,
    output logic [NumPads-1:0] pad_ds1_o,
    output logic [NumPads-1:0] pad_pe_o,
    output logic [NumPads-1:0] pad_ps_o,
    output logic [NumPads-1:0] pad_sr_o,
    output logic [NumPads-1:0] pad_is_o,
    input  logic [NumPads-1:0] pad_y_i
);
    localparam int IdxW = (NumPads > 1) ? $clog2(NumPads) : 1;
    localparam int CntW = (TurnCycles > 1) ? $clog2(TurnCycles) : 1;
    localparam logic [IdxW:0]   NumPadsW = (IdxW+1)'(NumPads);
    localparam logic [CntW-1:0] CntInit  = CntW'(TurnCycles - 1);

    typedef enum logic {IDLE, TURN} state_e;

    state_e          state, state_nxt;
    logic [CntW-1:0] cnt;
    logic [IdxW-1:0] cap_idx;
    logic [7:0]      cap_data;

    logic            gnt, idx_ok, dir_flip, start_turn, wr_en;
    logic [IdxW-1:0] wr_idx;
    logic [7:0]      wr_data;
    logic [SyncStages-1:0][NumPads-1:0] sync_q;

    assign idx_ok   = {1'b0, cfg.cfg_idx_i} < NumPadsW;
    assign dir_flip = idx_ok && (cfg.cfg_data_i[0] != pad_oe_o[cfg.cfg_idx_i]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_idx  <= '0;
            cap_data <= '0;
        end else begin
            state <= state_nxt;
            if (start_turn) begin
                cnt      <= CntInit;
                cap_idx  <= cfg.cfg_idx_i;
                cap_data <= cfg.cfg_data_i;
            end else if (state == TURN && cnt != '0) begin
                cnt <= cnt - CntW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_turn) state_nxt = TURN;
            TURN:    if (cnt == '0)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pad writes come either from a same-direction grant or from the
    // captured config at the end of a turnaround; never both in one cycle.
    always_comb begin
        gnt        = cfg.cfg_req_i && (state == IDLE);
        start_turn = gnt && dir_flip;
        wr_en      = 1'b0;
        wr_idx     = cfg.cfg_idx_i;
        wr_data    = cfg.cfg_data_i;
        if (state == IDLE) begin
            wr_en = gnt && idx_ok && !dir_flip;
        end else if (cnt == '0) begin
            wr_en   = 1'b1;
            wr_idx  = cap_idx;
            wr_data = cap_data;
        end
        cfg.cfg_gnt_o   = gnt;
        cfg.busy_o      = (state == TURN);
        cfg.cfg_rdata_o = '0;
        if (idx_ok)
            cfg.cfg_rdata_o = {pad_is_o[cfg.cfg_idx_i], pad_sr_o[cfg.cfg_idx_i],
                               pad_ps_o[cfg.cfg_idx_i], pad_pe_o[cfg.cfg_idx_i],
                               pad_ds1_o[cfg.cfg_idx_i], pad_ds0_o[cfg.cfg_idx_i],
                               pad_ie_o[cfg.cfg_idx_i], pad_oe_o[cfg.cfg_idx_i]};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pad_a_o   <= '0;
            pad_oe_o  <= '0;
            pad_ie_o  <= '0;
            pad_ds0_o <= '0;
            pad_ds1_o <= '0;
            pad_pe_o  <= '0;
            pad_ps_o  <= '0;
            pad_sr_o  <= '0;
            pad_is_o  <= '0;
        end else begin
            pad_a_o <= gpio_out_i;
            if (wr_en) begin
                pad_oe_o[wr_idx]  <= wr_data[0];
                pad_ie_o[wr_idx]  <= wr_data[1];
                pad_ds0_o[wr_idx] <= wr_data[2];
                pad_ds1_o[wr_idx] <= wr_data[3];
                pad_pe_o[wr_idx]  <= wr_data[4];
                pad_ps_o[wr_idx]  <= wr_data[5];
                pad_sr_o[wr_idx]  <= wr_data[6];
                pad_is_o[wr_idx]  <= wr_data[7];
            end else if (start_turn) begin
                pad_oe_o[cfg.cfg_idx_i] <= 1'b0;
                pad_ie_o[cfg.cfg_idx_i] <= 1'b0;
            end
        end
    end

    // Gating with IE keeps a floating receiver output out of the chain.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= pad_ie_o & pad_y_i;
            for (int s = 1; s < SyncStages; s++)
                sync_q[s] <= sync_q[s-1];
        end
    end

    assign gpio_in_o = sync_q[SyncStages-1];
endmodule

// File: tb/tb_pad_ctrl_seq.sv
// Random plus directed stimulus against a cycle-numbered reference model;
// expected outputs are queued per cycle and checked by a negedge monitor.
module tb_pad_ctrl_seq;
    localparam int NP = 6;
    localparam int TC = 2;
    localparam int SS = 2;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pad_ctrl_seq_if #(.NumPads(NP)) cfg();

    logic [NP-1:0] gpio_out, gpio_in, pa, poe, pie, pds0, pds1, ppe, pps, psr, pis, py;

    pad_ctrl_seq #(.NumPads(NP), .TurnCycles(TC), .SyncStages(SS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg(cfg.slave),
        .gpio_out_i(gpio_out), .gpio_in_o(gpio_in),
        .pad_a_o(pa), .pad_oe_o(poe), .pad_ie_o(pie), .pad_ds0_o(pds0), .pad_ds1_o(pds1),
        .pad_pe_o(ppe), .pad_ps_o(pps), .pad_sr_o(psr), .pad_is_o(pis), .pad_y_i(py)
    );

    typedef struct packed {
        logic          gnt;
        logic          busy;
        logic [7:0]    rdata;
        logic [NP-1:0] a, oe, ie, ds0, ds1, pe, ps, sr, is_, gin;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   kcyc  = 0;
    bit   mon_en = 1'b0;

    // Reference model: config per pad, plus cycle numbers for the busy window
    // and for when a pending direction-change config becomes visible.
    logic [7:0]    m_cfg [NP];
    logic [NP-1:0] m_a;
    logic [NP-1:0] m_st [SS];
    int            m_pend_at, m_busy_lo, m_busy_hi;
    int            m_pend_idx;
    logic [7:0]    m_pend_data;

    task automatic model_reset();
        for (int p = 0; p < NP; p++) m_cfg[p] = '0;
        for (int s = 0; s < SS; s++) m_st[s] = '0;
        m_a = '0;
        m_pend_at = -1;
        m_busy_lo = 1;
        m_busy_hi = 0;
    endtask

    function automatic logic [NP-1:0] field(int b);
        logic [NP-1:0] v;
        for (int p = 0; p < NP; p++) v[p] = m_cfg[p][b];
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, kcyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty cyc=%0d got=0 want=1", kcyc);
            end else begin
                e = q.pop_front();
                chk("gnt",   64'(cfg.cfg_gnt_o),   64'(e.gnt));
                chk("busy",  64'(cfg.busy_o),      64'(e.busy));
                chk("rdata", 64'(cfg.cfg_rdata_o), 64'(e.rdata));
                chk("pad_a", 64'(pa),              64'(e.a));
                chk("oe",    64'(poe),             64'(e.oe));
                chk("ie",    64'(pie),             64'(e.ie));
                chk("ds",    64'({pds1, pds0}),    64'({e.ds1, e.ds0}));
                chk("misc",  64'({pis, psr, pps, ppe}), 64'({e.is_, e.sr, e.ps, e.pe}));
                chk("gpio_in", 64'(gpio_in),       64'(e.gin));
            end
        end
    end

    // One clock cycle: drive inputs, queue the expected outputs, then advance the model.
    task automatic step(input logic r, input logic rq, input logic [IW-1:0] i,
                        input logic [7:0] d, input logic [NP-1:0] go,
                        input logic [NP-1:0] y, output logic g);
        exp_t x;
        logic busy;
        logic [NP-1:0] ie_now;
        rst_n = r;
        cfg.cfg_req_i  = rq;
        cfg.cfg_idx_i  = i;
        cfg.cfg_data_i = d;
        gpio_out = go;
        py = y;

        busy    = (kcyc >= m_busy_lo) && (kcyc <= m_busy_hi);
        g       = rq && !busy;
        x.gnt   = g;
        x.busy  = busy;
        x.rdata = '0;
        if (int'(i) < NP) x.rdata = m_cfg[i];
        x.a   = m_a;
        x.oe  = field(0);
        x.ie  = field(1);
        x.ds0 = field(2);
        x.ds1 = field(3);
        x.pe  = field(4);
        x.ps  = field(5);
        x.sr  = field(6);
        x.is_ = field(7);
        x.gin = m_st[SS-1];
        q.push_back(x);

        if (!r) begin
            model_reset();
        end else begin
            ie_now = field(1);
            for (int s = SS-1; s > 0; s--) m_st[s] = m_st[s-1];
            m_st[0] = ie_now & y;
            m_a = go;
            if (g && int'(i) < NP) begin
                if (d[0] == m_cfg[i][0]) begin
                    m_cfg[i] = d;
                end else begin
                    m_cfg[i][1:0] = 2'b00;
                    m_pend_at   = kcyc + TC + 1;
                    m_pend_idx  = int'(i);
                    m_pend_data = d;
                    m_busy_lo   = kcyc + 1;
                    m_busy_hi   = kcyc + TC;
                end
            end
            if (m_pend_at == kcyc + 1) begin
                m_cfg[m_pend_idx] = m_pend_data;
                m_pend_at = -1;
            end
        end
        @(posedge clk);
        #1;
        kcyc++;
    endtask

    initial begin
        logic g;
        logic [NP-1:0] yz;
        rst_n = 1'b0;
        cfg.cfg_req_i = 1'b0;
        cfg.cfg_idx_i = '0;
        cfg.cfg_data_i = '0;
        gpio_out = '0;
        py = '0;
        model_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // reset held with random inputs
        repeat (3) step(1'b0, 1'($urandom), IW'($urandom), 8'($urandom),
                        NP'($urandom), NP'($urandom), g);
        repeat (2) step(1'b1, 1'b0, '0, '0, '0, '0, g);

        // same-direction write on an input pad
        step(1'b1, 1'b1, 3'd3, 8'hFE, NP'($urandom), '0, g);
        repeat (2) step(1'b1, 1'b0, '0, '0, NP'($urandom), '0, g);

        // pad 5: enable input, then flip to output; queued request on pad 1
        step(1'b1, 1'b1, 3'd5, 8'h02, '0, '0, g);
        step(1'b1, 1'b0, '0, '0, '0, '0, g);
        step(1'b1, 1'b1, 3'd5, 8'h03, '0, '0, g);
        for (int n = 0; n < 8; n++) begin
            step(1'b1, 1'b1, 3'd1, 8'h01, NP'($urandom), '0, g);
            if (g) break;
        end
        repeat (5) step(1'b1, 1'b0, 3'd5, '0, '0, '0, g);

        // input synchroniser on pad 2, then Z with IE low
        step(1'b1, 1'b1, 3'd2, 8'h02, '0, '0, g);
        step(1'b1, 1'b0, '0, '0, '0, '0, g);
        repeat (4) step(1'b1, 1'b0, '0, '0, '0, 6'b000100, g);
        step(1'b1, 1'b1, 3'd2, 8'h00, '0, 6'b000100, g);
        yz = '0;
        yz[2] = 1'bz;
        repeat (4) step(1'b1, 1'b0, 3'd2, '0, '0, yz, g);

        // reset in the middle of a turnaround
        step(1'b1, 1'b1, 3'd0, 8'h01, '0, '0, g);
        step(1'b0, 1'b0, '0, '0, '0, '0, g);
        repeat (4) step(1'b1, 1'b0, 3'd0, '0, '0, '0, g);

        // out-of-range indices
        step(1'b1, 1'b1, 3'd6, 8'hFF, '0, '0, g);
        step(1'b1, 1'b1, 3'd7, 8'hFE, '0, '0, g);
        repeat (2) step(1'b1, 1'b0, 3'd6, '0, '0, '0, g);

        repeat (400)
            step(1'($urandom_range(0, 49) != 0), 1'($urandom), IW'($urandom),
                 8'($urandom), NP'($urandom), NP'($urandom), g);

        step(1'b1, 1'b0, '0, '0, '0, '0, g);
        mon_en = 1'b0;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
